water_led_ctrl: RTL
===================

# water_led_ctrl

Parametrised running-light controller, the next generation of the fixed 8-LED water-light block. It drives a configurable-width LED bar and a configurable number of RGB LEDs from a single board clock, with run-time selectable pattern modes, pause, a step strobe output and an optional PWM-dimmed trailing LED. It sits directly under the board top level, fed by the PLL output clock, and drives the board LED pins.

## Interface
- `LED_N`, default 8: LED bar width, minimum 2.
- `RGB_N`, default 4: number of RGB LEDs, minimum 1.
- `STEP_CYCLES`, default 12_000_000: clock cycles per pattern step, minimum 2.
- `ACTIVE_LOW`, default 0: when 1, the `led` and `rgb` outputs are inverted at the output register.

Ports:
- `clk` in 1: system clock; the only clock in the block.
- `rst` in 1: reset; synchronous and active-high.
- `mode` in 2: pattern select. 0 = ROTL, 1 = ROTR, 2 = BOUNCE, 3 = FILL.
- `pause` in 1: when high, freezes the prescaler, pattern and colours.
- `led` out LED_N: LED bar drive, registered.
- `rgb` out 3*RGB_N: RGB drive. Bits [3i+2:3i] = {R,G,B} of LED i. Registered.
- `step` out 1: one-cycle pulse, registered, on every pattern update.

## Operation
- Prescaler `pcnt`, width $clog2(STEP_CYCLES):
  - Counts 0..STEP_CYCLES-1 and wraps.
  - Internal tick when `pcnt == STEP_CYCLES-1` and `pause` is low.
- On a tick, the pattern advances by one step according to `mode`:
  - **ROTL:** one-hot pattern shifts left; bit LED_N-1 wraps to bit 0. Load value: 0..01.
  - **ROTR:** one-hot pattern shifts right; bit 0 wraps to bit LED_N-1. Load value: 10..0.
  - **BOUNCE:** one-hot pattern moves left to the MSB, then right to bit 0, then repeats.
    - End positions are shown once each; period is 2*LED_N-2 steps.
    - Direction flag `dir` flips on the step that reaches an end.
    - Load value: 0..01, `dir` = left.
  - **FILL:** pattern becomes (p<<1)|1 until all ones; the step after all ones is all zeros; the step after all zeros is 0..01.
    - Period is LED_N+1 steps. Load value: 0..01.
- Mode change:
  - `mode` is registered as `mode_q`.
  - When `mode != mode_q` and `pause` is low, the next edge loads the new mode's load value, clears `pcnt` to 0, and sets `dir` to left.
  - `step` does not pulse on a mode-change reload.
- Colour index `cidx` (0..6) increments mod 7 on every tick.
  - RGB LED i shows colour code ((cidx + i) mod 7) + 1, in the range 1..7. RGB LEDs are never fully off.
- `pause` high:
  - `pcnt`, the pattern, `cidx`, `dir` and the tail state all hold.
  - Mode changes are ignored; a change is applied after `pause` goes low.
- `ACTIVE_LOW` is applied after all pattern and tail logic, to `led` and `rgb` only.

## Timing
- Reset values (logical, before `ACTIVE_LOW` inversion):
  - `led` = 0..01, `rgb` = colour codes 1,2,3,… for LED 0,1,2,…, `step` = 0.
  - `pcnt` = 0, `cidx` = 0, `dir` = left, `mode_q` = `mode`.
- Step cadence:
  - The first tick after reset occurs STEP_CYCLES cycles after `rst` is released.
  - The tick updates `led`, `rgb` and `step` on the same edge. Latency from tick condition to outputs is 1 cycle.
  - `step` is high for exactly 1 cycle per update.
- Priority when events coincide: `rst` > `pause` > mode-change reload > tick.
  - A mode change in the tick cycle performs the reload only; no step is taken.
- `rst` asserted mid-step or mid-pattern: all state returns to reset values on the next edge, regardless of `pause`.

## Configuration
- Macro `WATER_LED_TAIL_EN`.
  - **Defined:** in ROTL, ROTR and BOUNCE, the LED lit before the last step stays on at 25% duty.
    - 2-bit free-running counter `pwm`, reset to 0; it also runs during `pause`.
    - The tail bit is ORed into `led` when `pwm == 0`.
    - The tail register is cleared on reset and on a mode-change reload, and is unused in FILL.
  - **Not defined:** no tail logic or PWM counter is built; `led` equals the pattern exactly.

## Test plan
- LED_N=8, RGB_N=4, STEP_CYCLES=4, mode=0 after reset -> `led` 0x01, 0x02, …, 0x80, 0x01. Each change occurs 4 cycles apart with `step` pulsing in the same cycle.
- mode=2 -> `led` 0x01, 0x02, …, 0x80, 0x40, …, 0x01, 0x02. Each of 0x80 and 0x01 appears once per 14-step period.
- mode=3 -> `led` 0x01, 0x03, 0x07, …, 0xFF, 0x00, 0x01. Period 9 steps.
- In ROTL after 3 steps (`led` = 0x08), raise `pause` for 20 cycles -> `led` and `rgb` unchanged, no `step` pulse. Then switch to mode=1 and drop `pause` -> next edge gives `led` = 0x80, `pcnt` = 0, no `step` pulse.
- RGB check: from reset, after 6 steps `cidx` = 6 -> `rgb` codes {LED0..LED3} = 7,1,2,3. With ACTIVE_LOW=1, every `led`/`rgb` bit is the inverse of the ACTIVE_LOW=0 run.
- With `WATER_LED_TAIL_EN` defined, mode 0 at `led` pattern 0x04 -> bit 1 is high exactly 1 of every 4 cycles, and bit 2 is high continuously. In mode 3 no tail bit ever appears.

Source files
------------

// File: rtl/water_led_ctrl.sv
// water_led_ctrl: running-light controller for a LED_N-wide LED bar plus RGB_N RGB LEDs.
// Optional feature: define WATER_LED_TAIL_EN to add a 25%-duty trailing LED in ROTL/ROTR/BOUNCE.
module water_led_ctrl #(
    parameter int LED_N       = 8,
    parameter int RGB_N       = 4,
    parameter int STEP_CYCLES = 12_000_000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               pause,
    output logic [LED_N-1:0]   led,
    output logic [3*RGB_N-1:0] rgb,
    output logic               step
);

    localparam int                PW       = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0]     PCNT_MAX = PW'(STEP_CYCLES - 1);
    localparam logic [LED_N-1:0]  LOAD_LSB = LED_N'(1);
    localparam logic [LED_N-1:0]  LOAD_MSB = {1'b1, {(LED_N-1){1'b0}}};
    localparam logic [LED_N-1:0]  ALL_ONES = '1;
    localparam logic [LED_N-1:0]  LED_POL  = ACTIVE_LOW ? '1 : '0;
    localparam logic [3*RGB_N-1:0] RGB_POL = ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'd0,
        MODE_ROTR   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Colour code 1..7 for RGB LED idx when the colour index is cidx.
    function automatic logic [2:0] colour_code(input logic [2:0] cidx, input int idx);
        logic [3:0] s;
        s = {1'b0, cidx} + 4'(idx % 7);
        if (s >= 4'd7) begin
            s = s - 4'd7;
        end
        return s[2:0] + 3'd1;
    endfunction

    mode_e             w_mode;
    mode_e             r_mode_q;
    mode_e             w_mode_q_next;
    dir_e              r_dir;
    dir_e              w_dir_next;
    dir_e              w_adv_dir;
    logic [PW-1:0]     r_pcnt;
    logic [PW-1:0]     w_pcnt_next;
    logic [LED_N-1:0]  r_pat;
    logic [LED_N-1:0]  w_pat_next;
    logic [LED_N-1:0]  w_adv_pat;
    logic [LED_N-1:0]  w_load_val;
    logic [LED_N-1:0]  w_tail_mask;
    logic [2:0]        r_cidx;
    logic [2:0]        w_cidx_next;
    logic              r_step;
    logic              w_step_next;
    logic              w_reload;
    logic              w_tick;
    logic [LED_N-1:0]  r_led;
    logic [3*RGB_N-1:0] r_rgb;
    logic [3*RGB_N-1:0] w_rgb_next;
    logic [3*RGB_N-1:0] w_rgb_rst;

    assign w_mode   = mode_e'(mode);
    assign w_reload = !pause && (w_mode != r_mode_q);
    assign w_tick   = !pause && !w_reload && (r_pcnt == PCNT_MAX);

    assign w_load_val = (w_mode == MODE_ROTR) ? LOAD_MSB : LOAD_LSB;

    // One pattern step in the currently registered mode.
    always_comb begin
        w_adv_pat = r_pat;
        w_adv_dir = r_dir;
        case (r_mode_q)
            MODE_ROTL: begin
                w_adv_pat = {r_pat[LED_N-2:0], r_pat[LED_N-1]};
            end
            MODE_ROTR: begin
                w_adv_pat = {r_pat[0], r_pat[LED_N-1:1]};
            end
            MODE_BOUNCE: begin
                if (r_dir == DIR_LEFT) begin
                    w_adv_pat = r_pat << 1;
                    if (w_adv_pat[LED_N-1]) begin
                        w_adv_dir = DIR_RIGHT;
                    end
                end else begin
                    w_adv_pat = r_pat >> 1;
                    if (w_adv_pat[0]) begin
                        w_adv_dir = DIR_LEFT;
                    end
                end
            end
            default: begin
                w_adv_pat = (r_pat == ALL_ONES) ? '0 : {r_pat[LED_N-2:0], 1'b1};
            end
        endcase
    end

    // Priority below reset: pause, then mode-change reload, then tick.
    always_comb begin
        w_pcnt_next   = r_pcnt;
        w_pat_next    = r_pat;
        w_mode_q_next = r_mode_q;
        w_dir_next    = r_dir;
        w_cidx_next   = r_cidx;
        w_step_next   = 1'b0;
        if (pause) begin
            w_step_next = 1'b0;
        end else if (w_reload) begin
            w_mode_q_next = w_mode;
            w_pat_next    = w_load_val;
            w_pcnt_next   = '0;
            w_dir_next    = DIR_LEFT;
        end else if (w_tick) begin
            w_pcnt_next = '0;
            w_pat_next  = w_adv_pat;
            w_dir_next  = w_adv_dir;
            w_cidx_next = (r_cidx == 3'd6) ? 3'd0 : r_cidx + 3'd1;
            w_step_next = 1'b1;
        end else begin
            w_pcnt_next = r_pcnt + PW'(1);
        end
    end

`ifdef WATER_LED_TAIL_EN
    logic [LED_N-1:0] r_tail;
    logic [LED_N-1:0] w_tail_next;
    logic [1:0]       r_pwm;
    logic [1:0]       w_pwm_next;

    assign w_pwm_next = r_pwm + 2'd1;

    always_comb begin
        w_tail_next = r_tail;
        if (w_reload) begin
            w_tail_next = '0;
        end else if (w_tick) begin
            w_tail_next = r_pat;
        end
    end

    // The PWM counter keeps running through pause so the tail still dims.
    assign w_tail_mask = ((w_mode_q_next != MODE_FILL) && (w_pwm_next == 2'd0)) ? w_tail_next : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tail <= '0;
            r_pwm  <= 2'd0;
        end else begin
            r_tail <= w_tail_next;
            r_pwm  <= w_pwm_next;
        end
    end
`else
    assign w_tail_mask = '0;
`endif

    generate
        for (genvar gi = 0; gi < RGB_N; gi++) begin : g_rgb
            assign w_rgb_next[3*gi +: 3] = colour_code(w_cidx_next, gi);
            assign w_rgb_rst[3*gi +: 3]  = colour_code(3'd0, gi);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt   <= '0;
            r_pat    <= LOAD_LSB;
            r_mode_q <= w_mode;
            r_dir    <= DIR_LEFT;
            r_cidx   <= 3'd0;
            r_step   <= 1'b0;
            r_led    <= LOAD_LSB ^ LED_POL;
            r_rgb    <= w_rgb_rst ^ RGB_POL;
        end else begin
            r_pcnt   <= w_pcnt_next;
            r_pat    <= w_pat_next;
            r_mode_q <= w_mode_q_next;
            r_dir    <= w_dir_next;
            r_cidx   <= w_cidx_next;
            r_step   <= w_step_next;
            r_led    <= (w_pat_next | w_tail_mask) ^ LED_POL;
            r_rgb    <= w_rgb_next ^ RGB_POL;
        end
    end

    assign led  = r_led;
    assign rgb  = r_rgb;
    assign step = r_step;

endmodule
